// File: rtl/rtdc_gen2.sv
// rtdc_gen2: parametrised 24 h real-time clock with seven-segment display, time load and alarm
module rtdc_gen2 #(
  parameter int CLK_DIV = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_12h,
  input  logic       set_en,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic [6:0] HRM,
  output logic [6:0] HRL,
  output logic [6:0] MIN_M,
  output logic [6:0] MIN_L,
  output logic [6:0] SEC_M,
  output logic [6:0] SEC_L,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_hit,
  output logic       set_err
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  logic [PW-1:0] pre;
  logic [4:0] hr, hr_n, hd;
  logic [5:0] mn, mn_n, sc, sc_n;
  logic set_ok, load, tick, adv, sc_w, mn_w, al_m;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s ^ {7{SEG_ACTIVE_LOW}};
  endfunction
  always_comb begin
    set_ok = set_hr <= 5'd23 && set_min <= 6'd59 && set_sec <= 6'd59;
    load = set_en && set_ok;
    tick = pre == PMAX;
    adv = tick && !load;
    sc_w = sc == 6'd59;
    mn_w = mn == 6'd59;
    sc_n = sc_w ? 6'd0 : sc + 6'd1;
    mn_n = !sc_w ? mn : mn_w ? 6'd0 : mn + 6'd1;
    hr_n = !(sc_w && mn_w) ? hr : hr == 5'd23 ? 5'd0 : hr + 5'd1;
    // out-of-range alarm fields can never equal a legal next time
    al_m = alarm_en && sc_n == 6'd0 && mn_n == alarm_min && hr_n == alarm_hr;
    hd = !mode_12h ? hr : hr == 5'd0 ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      hr <= '0;
      mn <= '0;
      sc <= '0;
      sec_tick <= 1'b0;
      alarm_hit <= 1'b0;
      set_err <= 1'b0;
    end else begin
      pre <= load || tick ? '0 : pre + PW'(1);
      if (load) begin
        hr <= set_hr;
        mn <= set_min;
        sc <= set_sec;
      end else if (tick) begin
        hr <= hr_n;
        mn <= mn_n;
        sc <= sc_n;
      end
      sec_tick <= adv;
      alarm_hit <= adv && al_m;
      set_err <= set_en && !set_ok;
    end
  end
  assign HRM = seg7(4'(hd / 5'd10));
  assign HRL = seg7(4'(hd % 5'd10));
  assign MIN_M = seg7(4'(mn / 6'd10));
  assign MIN_L = seg7(4'(mn % 6'd10));
  assign SEC_M = seg7(4'(sc / 6'd10));
  assign SEC_L = seg7(4'(sc % 6'd10));
  assign pm = hr >= 5'd12;
endmodule

// File: tb/tb_rtdc_gen2.sv
// tb_rtdc_gen2: directed tables, corner sequences and random stimulus against a seconds-of-day model
module tb_rtdc_gen2;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode_12h = 1'b0, set_en = 1'b0, alarm_en = 1'b0;
  logic [4:0] set_hr = '0, alarm_hr = '0;
  logic [5:0] set_min = '0, set_sec = '0, alarm_min = '0;
  logic [6:0] HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L;
  logic [6:0] HRM_i, HRL_i, MIN_M_i, MIN_L_i, SEC_M_i, SEC_L_i;
  logic pm, sec_tick, alarm_hit, set_err;
  logic pm_i, sec_tick_i, alarm_hit_i, set_err_i;
  int nchk = 0, nerr = 0;
  int t, p;
  bit e_tick, e_alarm, e_err;
  always #5 clk = ~clk;
  rtdc_gen2 #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_en(set_en), .set_hr(set_hr),
    .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en), .alarm_hr(alarm_hr),
    .alarm_min(alarm_min), .HRM(HRM), .HRL(HRL), .MIN_M(MIN_M), .MIN_L(MIN_L),
    .SEC_M(SEC_M), .SEC_L(SEC_L), .pm(pm), .sec_tick(sec_tick), .alarm_hit(alarm_hit),
    .set_err(set_err));
  rtdc_gen2 #(.CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut_i (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_en(set_en), .set_hr(set_hr),
    .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en), .alarm_hr(alarm_hr),
    .alarm_min(alarm_min), .HRM(HRM_i), .HRL(HRL_i), .MIN_M(MIN_M_i), .MIN_L(MIN_L_i),
    .SEC_M(SEC_M_i), .SEC_L(SEC_L_i), .pm(pm_i), .sec_tick(sec_tick_i),
    .alarm_hit(alarm_hit_i), .set_err(set_err_i));
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction
  task automatic chk(input string name, input longint got, input longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    t = 0; p = 0; e_tick = 0; e_alarm = 0; e_err = 0;
  endtask
  // model step from the inputs held across the coming rising edge
  task automatic model_step();
    bit ok;
    e_tick = 0; e_alarm = 0; e_err = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    ok = set_hr < 24 && set_min < 60 && set_sec < 60;
    if (set_en && ok) begin
      t = set_hr * 3600 + set_min * 60 + set_sec;
      p = 0;
    end else begin
      e_err = set_en;
      if (p == DIV - 1) begin
        p = 0;
        t = (t + 1) % 86400;
        e_tick = 1;
        e_alarm = alarm_en && alarm_hr < 24 && alarm_min < 60 &&
                  t == alarm_hr * 3600 + alarm_min * 60;
      end else p++;
    end
  endtask
  task automatic check_all();
    int h, m, s, hd;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    hd = !mode_12h ? h : (h % 12 == 0 ? 12 : h % 12);
    chk("HRM", HRM, seg(hd / 10));
    chk("HRL", HRL, seg(hd % 10));
    chk("MIN_M", MIN_M, seg(m / 10));
    chk("MIN_L", MIN_L, seg(m % 10));
    chk("SEC_M", SEC_M, seg(s / 10));
    chk("SEC_L", SEC_L, seg(s % 10));
    chk("seg_inv", {HRM_i, HRL_i, MIN_M_i, MIN_L_i, SEC_M_i, SEC_L_i},
        {seg(hd / 10), seg(hd % 10), seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)} ^ {42{1'b1}});
    chk("pm", pm, h >= 12);
    chk("sec_tick", sec_tick, e_tick);
    chk("alarm_hit", alarm_hit, e_alarm);
    chk("set_err", set_err, e_err);
    chk("flags_inv", {pm_i, sec_tick_i, alarm_hit_i, set_err_i}, {h >= 12, e_tick, e_alarm, e_err});
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic load(input int h, input int m, input int s);
    set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s); set_en = 1'b1;
    cyc();
    set_en = 1'b0;
  endtask
  typedef struct {
    bit m12;
    int h, mi, s;
    logic [41:0] e;
    bit epm;
  } vec_t;
  vec_t tbl[8];
  int cnt;
  initial begin
    tbl[0] = '{1'b1, 13, 5, 0, {7'h3F, 7'h06, 7'h3F, 7'h6D, 7'h3F, 7'h3F}, 1'b1};
    tbl[1] = '{1'b0, 13, 5, 0, {7'h06, 7'h4F, 7'h3F, 7'h6D, 7'h3F, 7'h3F}, 1'b1};
    tbl[2] = '{1'b1, 0, 0, 0, {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0};
    tbl[3] = '{1'b1, 12, 34, 56, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 1'b1};
    tbl[4] = '{1'b0, 23, 59, 59, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b1};
    tbl[5] = '{1'b1, 23, 59, 59, {7'h06, 7'h06, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b1};
    tbl[6] = '{1'b0, 9, 8, 7, {7'h3F, 7'h6F, 7'h3F, 7'h7F, 7'h3F, 7'h07}, 1'b0};
    tbl[7] = '{1'b1, 11, 0, 0, {7'h06, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0};
    model_reset();
    #2;
    check_all();
    chk("rst_SEC_L_inv", SEC_L_i, 7'h40);
    mode_12h = 1'b1;
    #1;
    check_all();
    chk("rst_12h_hr", {HRM, HRL}, {7'h06, 7'h5B});
    mode_12h = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      cnt += sec_tick;
      if (i == 2) chk("pre_tick_SEC_L", SEC_L, 7'h3F);
      if (i == 3) chk("first_tick_SEC_L", {SEC_L, sec_tick}, {7'h06, 1'b1});
    end
    chk("tick_cnt", cnt, 3);
    for (int i = 0; i < $size(tbl); i++) begin
      load(tbl[i].h, tbl[i].mi, tbl[i].s);
      mode_12h = tbl[i].m12;
      #1;
      check_all();
      chk("tbl_seg", {HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L}, tbl[i].e);
      chk("tbl_pm", pm, tbl[i].epm);
      mode_12h = ~mode_12h;
      #1;
      check_all();
    end
    mode_12h = 1'b1;
    load(23, 59, 59);
    for (int i = 0; i < DIV; i++) cyc();
    chk("wrap_12h", {HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L, pm}, {7'h06, 7'h5B, {4{7'h3F}}, 1'b0});
    mode_12h = 1'b0;
    #1;
    chk("wrap_24h", {HRM, HRL}, {7'h3F, 7'h3F});
    load(10, 20, 30);
    cyc();
    load(24, 0, 0);
    chk("err24", {set_err, HRL}, {1'b1, 7'h3F});
    load(10, 60, 0);
    chk("err60", {set_err, MIN_M}, {1'b1, 7'h5B});
    cyc();
    chk("err_clear", set_err, 0);
    for (int i = 0; i < 2 * DIV && p != DIV - 1; i++) cyc();
    load(5, 6, 7);
    chk("load_over_tick", {SEC_L, sec_tick}, {7'h07, 1'b0});
    alarm_hr = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alarm_en = k != 1;
      load(7, k == 2 ? 30 : 29, k == 2 ? 0 : 59);
      cnt = 0;
      for (int i = 0; i < 2 * DIV; i++) begin
        cyc();
        cnt += alarm_hit;
      end
      chk("alarm_cnt", cnt, k == 0 ? 1 : 0);
    end
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst", {HRM, SEC_L, SEC_L_i}, {7'h3F, 7'h3F, 7'h40});
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      set_en = $urandom % 6 == 0;
      set_hr = 5'($urandom % 26);
      set_min = 6'($urandom % 62);
      set_sec = $urandom % 2 ? 6'(55 + $urandom % 7) : 6'($urandom % 60);
      if (set_en) begin
        alarm_hr = set_hr;
        alarm_min = set_min + 6'd1;
        alarm_en = $urandom % 4 != 0;
      end
      if ($urandom % 16 == 0) mode_12h = ~mode_12h;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
